// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial comparator: FSM states and decision encoding.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_GT = 2'd1,
    DEC_LT = 2'd2
  } dec_e;

  // The first differing MSB-first bit pair settles the magnitude; later bits never change it.
  function automatic dec_e dec_step(input dec_e cur, input logic a, input logic b);
    dec_e nxt;
    nxt = cur;
    if ((cur == DEC_EQ) && (a != b)) begin
      nxt = a ? DEC_GT : DEC_LT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cmp_shift_reg.sv
// WIDTH-bit serial-in/parallel-out shift register, shifts left with new bit in the LSB.
// Latency: bit presented with en=1 appears in word_q the following cycle.
// Backpressure: none; en low simply holds the contents, clr has priority over en.
module cmp_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word_q
);

  logic [WIDTH-1:0] word_d;

  // Next contents: clear, shift in a new LSB, or hold.
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (en) begin
      word_d = {word_q[WIDTH-2:0], din};
    end
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator: MSB-first pairs in, registered EQ/GT/LT flags and words out.
// Latency: done pulses one cycle after the WIDTH-th valid pair; start-to-done is WIDTH+2 cycles minimum.
// Backpressure: bit_valid low stalls RUN indefinitely; abort returns to IDLE leaving results untouched.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             is_equal,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic [WIDTH-1:0] a_word,
  output logic [WIDTH-1:0] b_word
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  dec_e             dec_q, dec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] a_word_q, a_word_d;
  logic [WIDTH-1:0] b_word_q, b_word_d;

  logic             sh_clr;
  logic             sh_en;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;

  // A bit pair is consumed only in RUN, and abort in the same cycle discards it.
  assign sh_clr = (state_q == ST_IDLE) && start;
  assign sh_en  = (state_q == ST_RUN) && bit_valid && !abort;

  cmp_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .en     (sh_en),
    .din    (a_bit),
    .word_q (a_sh_q)
  );

  cmp_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .en     (sh_en),
    .din    (b_bit),
    .word_q (b_sh_q)
  );

  // FSM next state, bit counter, decision register and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    a_word_d = a_word_q;
    b_word_d = b_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          dec_d   = DEC_EQ;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_valid) begin
          cnt_d = cnt_q + 1'b1;
          dec_d = dec_step(dec_q, a_bit, b_bit);
          // Results are captured on the final pair so they are already registered in DONE.
          if (cnt_q == LAST_IDX) begin
            state_d  = ST_DONE;
            eq_d     = (dec_d == DEC_EQ);
            gt_d     = (dec_d == DEC_GT);
            lt_d     = (dec_d == DEC_LT);
            a_word_d = {a_sh_q[WIDTH-2:0], a_bit};
            b_word_d = {b_sh_q[WIDTH-2:0], b_bit};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dec_q    <= DEC_EQ;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      a_word_q <= '0;
      b_word_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dec_q    <= dec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      a_word_q <= a_word_d;
      b_word_q <= b_word_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign is_equal = eq_q;
  assign a_gt_b   = gt_q;
  assign a_lt_b   = lt_q;
  assign a_word   = a_word_q;
  assign b_word   = b_word_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: directed operand pairs with hand-derived flags.
// Latency: expects done exactly one cycle after the eighth valid pair.
// Backpressure: exercises bit_valid gaps, abort and mid-run reset.
module tb_serial_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         bit_valid;
  logic         a_bit;
  logic         b_bit;
  logic         busy;
  logic         done;
  logic         is_equal;
  logic         a_gt_b;
  logic         a_lt_b;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;

  // flags packed as {eq, gt, lt}
  typedef struct packed {
    logic [2:0]   flags;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .is_equal  (is_equal),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_word    (a_word),
    .b_word    (b_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        mon_e = exp_q.pop_front();
        chk("flags", {13'd0, is_equal, a_gt_b, a_lt_b}, {13'd0, mon_e.flags});
        chk("a_word", {8'd0, a_word}, {8'd0, mon_e.a});
        chk("b_word", {8'd0, b_word}, {8'd0, mon_e.b});
      end
    end
  end

  // Full comparison; a junk pair (a=1,b=0) accompanies start and must not be consumed.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] flags, input bit gap, input bit start_mid);
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    for (int i = W - 1; i >= 0; i--) begin
      if (gap) begin
        bit_valid = 1'b0;
        a_bit     = ~a[i];
        b_bit     = b[i];
        tick();
      end
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      start     = start_mid && (i == 4);
      if (i == 0) exp_q.push_back({flags, a, b});
      tick();
      if (i > 0) chk("no_early_done", {15'd0, done}, 16'd0);
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    chk("done_latency", {15'd0, done}, 16'd1);
    chk("busy_in_done", {15'd0, busy}, 16'd0);
    tick();
    chk("done_pulse", {15'd0, done}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_flags", {13'd0, is_equal, a_gt_b, a_lt_b}, 16'd0);
    chk("rst_words", {a_word, b_word}, 16'd0);

    // bit_valid in IDLE must be ignored
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    tick();
    bit_valid = 1'b0;
    chk("idle_bits_ignored", {15'd0, busy}, 16'd0);

    run_cmp(8'hA5, 8'hA5, 3'b100, 1'b0, 1'b0);
    run_cmp(8'h80, 8'h7F, 3'b010, 1'b0, 1'b0);
    run_cmp(8'h01, 8'h02, 3'b001, 1'b0, 1'b0);
    run_cmp(8'h55, 8'h54, 3'b010, 1'b0, 1'b1);
    run_cmp(8'h3C, 8'h3D, 3'b001, 1'b1, 1'b0);

    // Abort after four bits, together with a valid pair
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bit_valid = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    tick();
    tick();
    chk("abort_flags_held", {13'd0, is_equal, a_gt_b, a_lt_b}, 16'd1);
    chk("abort_words_held", {a_word, b_word}, 16'h3C3D);

    run_cmp(8'hFF, 8'hFF, 3'b100, 1'b0, 1'b0);

    // Reset after five bits discards the run and clears every output
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_done", {15'd0, done}, 16'd0);
    chk("mid_rst_flags", {13'd0, is_equal, a_gt_b, a_lt_b}, 16'd0);
    chk("mid_rst_words", {a_word, b_word}, 16'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_idle", {15'd0, busy}, 16'd0);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Bit-serial magnitude/equality comparator for the lab datapath. Accepts two WIDTH-bit operands shifted in MSB-first, one bit pair per valid cycle, and produces a registered equal/greater/less result plus the reassembled parallel words. Sits between a serial source (switch/UART-style bit stream) and parallel logic that consumes `is_equal` and the magnitude flags.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a comparison; honoured only in IDLE
- `abort`  in  1  cancel an in-progress comparison; returns to IDLE
- `bit_valid`  in  1  `a_bit`/`b_bit` carry a valid pair this cycle
- `a_bit`  in  1  operand A bit, MSB first
- `b_bit`  in  1  operand B bit, MSB first
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse when the result is valid
- `is_equal`  out  1  A == B
- `a_gt_b`  out  1  A > B (unsigned)
- `a_lt_b`  out  1  A < B (unsigned)
- `a_word`  out  WIDTH  reassembled operand A
- `b_word`  out  WIDTH  reassembled operand B

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN; clear bit counter, shift registers, decision register to EQ. Result outputs keep previous values until DONE.
- RUN: each cycle with `bit_valid`=1 shifts `a_bit`/`b_bit` into the LSB of the A/B shift registers (shift left) and increments counter. Cycles with `bit_valid`=0 stall, no state change.
- Decision register: starts EQ; on the first pair with `a_bit`≠`b_bit` it latches GT (a=1,b=0) or LT (a=0,b=1) and is frozen for the remaining bits.
- When the WIDTH-th valid pair is consumed → DONE.
- DONE (one cycle): `done`=1; `is_equal`/`a_gt_b`/`a_lt_b` and `a_word`/`b_word` load from decision and shift registers; → IDLE.
- Exactly one of the three flags is 1 after any completed comparison; all three 0 only after reset.
- `abort` in RUN → IDLE next cycle; no `done`, result outputs unchanged. `abort` in IDLE/DONE ignored.
- `abort` and `bit_valid` in the same cycle: abort wins, bit discarded.
- `start` in RUN or DONE ignored. `start` in IDLE with `bit_valid`=1 same cycle: bit not consumed.
- `bit_valid` in IDLE/DONE ignored.

## Timing
- Reset: state IDLE; `busy`, `done`, `is_equal`, `a_gt_b`, `a_lt_b` = 0; `a_word`, `b_word` = 0; counter 0. Reset mid-RUN discards the operation, no `done`.
- `start` at cycle t → `busy`=1 from t+1.
- WIDTH-th valid pair at cycle n → `done`=1 and results valid at n+1; `busy`=0 at n+1; earliest next `start` accepted at n+2.
- Minimum comparison length: 1 (start) + WIDTH (bits) + 1 (DONE) = WIDTH+2 cycles; WIDTH=8 → 10 cycles.
- All outputs registered; no combinational path from inputs to outputs.
- Counter width `$clog2(WIDTH+1)`; no wrap: leaves RUN exactly at WIDTH.

## Structure
- Package `serial_cmp_pkg`: state enum (IDLE, RUN, DONE), decision encoding (EQ, GT, LT).
- Sub-module `cmp_shift_reg` (WIDTH-bit serial-in/parallel-out, clear + enable), instantiated twice for A and B.
- FSM, counter, and decision register in the top module.

## Test plan
- Reset then start, stream A=8'hA5, B=8'hA5 with continuous `bit_valid` → `done` at cycle 10 after start, `is_equal`=1, `a_word`=`b_word`=8'hA5.
- A=8'h80, B=8'h7F → `a_gt_b`=1 decided at the first bit, later bits ignored; A=8'h01, B=8'h02 → `a_lt_b`=1.
- A=8'h3C, B=8'h3D with `bit_valid` toggling every other cycle → `done` 1 cycle after 8th valid bit, `a_lt_b`=1, words correct.
- Start, 4 bits, `abort` together with `bit_valid` → IDLE, no `done`, previous flags held; new run with A=B=8'hFF → `is_equal`=1.
- `start` pulsed during RUN and `rst` asserted after 5 bits → start ignored; after reset all outputs 0, `busy`=0, no `done`.
